// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single-ported memory
// with a fair tie-break and a per-grant ack timeout.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_ready,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          bus_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic       last_gnt;  // 1 = data port was granted last
  logic [9:0] wait_cnt;
  logic       timeout_hit;

  assign busy        = (state != IDLE);
  assign timeout_hit = (wait_cnt == TO_LAST) && !mem_ack;

  always_comb begin
    state_nx   = state;
    inst_ready = 1'b0;
    data_ready = 1'b0;
    inst_rdata = '0;
    data_rdata = '0;
    case (state)
      IDLE: begin
        // On a tie the port that was not served last wins.
        if (data_req && (!inst_req || !last_gnt)) state_nx = GNT_D;
        else if (inst_req)                        state_nx = GNT_I;
      end
      GNT_I: begin
        if (mem_ack) begin
          inst_ready = 1'b1;
          inst_rdata = mem_rdata;
          state_nx   = IDLE;
        end else if (timeout_hit) begin
          inst_ready = 1'b1;
          state_nx   = IDLE;
        end
      end
      GNT_D: begin
        if (mem_ack) begin
          data_ready = 1'b1;
          data_rdata = mem_rdata;
          state_nx   = IDLE;
        end else if (timeout_hit) begin
          data_ready = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b0;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        wait_cnt <= '0;
        if (state_nx == GNT_D) begin
          mem_req   <= 1'b1;
          mem_we    <= data_we;
          mem_addr  <= data_addr;
          mem_wdata <= data_wdata;
        end else if (state_nx == GNT_I) begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= inst_addr;
        end
      end else if (state_nx == IDLE) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        last_gnt <= (state == GNT_D);
        if (timeout_hit) bus_err <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 10'd1;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width in bits.
REQ-002 Parameter DW, 32, data width in bits.
REQ-003 Parameter TIMEOUT, 64, max cycles a grant waits for mem_ack before abort; legal range 1..1023.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 inst_req  in  1  fetch stage requests a read; held high until inst_ready is seen.
REQ-007 inst_addr  in  AW  fetch address; stable while inst_req is high.
REQ-008 inst_rdata  out  DW  fetch read data; valid only when inst_ready=1.
REQ-009 inst_ready  out  1  fetch transaction complete this cycle.
REQ-010 data_req  in  1  mem stage requests an access; held high until data_ready is seen.
REQ-011 data_we  in  1  1=write, 0=read; stable while data_req is high.
REQ-012 data_addr  in  AW  data address.
REQ-013 data_wdata  in  DW  write data.
REQ-014 data_rdata  out  DW  load data; valid only when data_ready=1 and the access was a read.
REQ-015 data_ready  out  1  data transaction complete this cycle.
REQ-016 mem_req  out  1  request to the single-ported memory.
REQ-017 mem_we  out  1  write strobe to memory.
REQ-018 mem_addr  out  AW  memory address.
REQ-019 mem_wdata  out  DW  memory write data.
REQ-020 mem_ack  in  1  memory completes the current request this cycle; mem_rdata valid with it.
REQ-021 mem_rdata  in  DW  memory read data.
REQ-022 busy  out  1  high whenever a grant is outstanding (state != IDLE).
REQ-023 bus_err  out  1  sticky; set on any timeout abort.

Function
REQ-024 FSM states: IDLE, GNT_I, GNT_D.
REQ-025 IDLE: data_req only -> GNT_D; inst_req only -> GNT_I; both -> the port NOT recorded in last_gnt; neither -> stay.
REQ-026 On entry to GNT_x, the arbiter registers that port's addr/we/wdata into mem_addr/mem_we/mem_wdata and drives mem_req=1 from the first cycle in GNT_x; these outputs stay constant until exit.
REQ-027 mem_we SHALL be 0 in GNT_I regardless of data_we.
REQ-028 In GNT_x, the cycle with mem_ack=1: x_ready=1 combinationally, x_rdata=mem_rdata, last_gnt<=x, next state IDLE, mem_req deasserts next cycle.
REQ-029 Minimum latency: request seen in IDLE at edge k -> mem_req high cycle k+1 -> earliest x_ready in cycle k+1 (zero-wait memory); one IDLE bubble cycle SHALL separate consecutive grants.
REQ-030 The non-granted port's ready SHALL stay 0; its rdata SHALL be 0 when its ready is 0.
REQ-031 mem_ack in IDLE SHALL be ignored (no ready, no state change).
REQ-032 A wait counter SHALL clear on grant entry and increment each GNT_x cycle without mem_ack; on the cycle count reaches TIMEOUT-1 with no ack: x_ready=1, x_rdata=0, bus_err<=1, last_gnt<=x, next state IDLE.
REQ-033 mem_ack arriving in the timeout cycle SHALL win: normal completion, no bus_err.
REQ-034 Requester dropping req mid-grant SHALL NOT abort the grant; the transaction completes and ready is still pulsed.
REQ-035 When mem_req=0, mem_we SHALL be 0; mem_addr/mem_wdata hold last values.
REQ-036 Fairness: with both requesters continuously asserting, grants SHALL strictly alternate D,I,D,I...

Reset
REQ-037 rst=1 at an edge: state<=IDLE, last_gnt<=INST (data wins first tie), wait counter<=0, bus_err<=0, mem_req/mem_we<=0, mem_addr/mem_wdata<=0.
REQ-038 inst_ready, data_ready, busy SHALL be 0 in the cycle after a reset edge; reset mid-grant abandons the transaction with no ready pulse.

Verification
REQ-039 Zero-wait read: inst_req=1 addr=0x0000_0040, mem_ack same cycle as mem_req with rdata=0x2008_0005 -> inst_ready=1, inst_rdata=0x2008_0005 in that cycle, busy=0 next cycle.
REQ-040 Tie after reset: inst_req and data_req (we=1, addr=0x10, wdata=0xCAFE_F00D) both raised -> first mem_req has mem_we=1, mem_addr=0x10; instruction granted after one IDLE bubble.
REQ-041 Alternation: both reqs held for 6 transactions, ack 2 cycles after each mem_req -> grant order D,I,D,I,D,I.
REQ-042 Timeout: TIMEOUT=4, data read, mem_ack never -> data_ready=1 with data_rdata=0 in 4th GNT_D cycle, bus_err=1 thereafter until rst.
REQ-043 Ack on timeout cycle: TIMEOUT=4, mem_ack in 4th cycle rdata=0x1234_5678 -> data_rdata=0x1234_5678, bus_err stays 0.
REQ-044 Reset mid-grant: rst in 2nd wait cycle of GNT_I -> next cycle mem_req=0, busy=0, no inst_ready pulse.
